// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
// Holds the frame FSM states and the data-width encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    // Index of the final data bit for a width code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] sel);
        logic [2:0] idx;
        idx = 3'd7;
        unique case (sel)
            DBITS_5: idx = 3'd4;
            DBITS_6: idx = 3'd5;
            DBITS_7: idx = 3'd6;
            DBITS_8: idx = 3'd7;
        endcase
        return idx;
    endfunction

    // Mask of the data bits actually sent for a width code.
    function automatic logic [7:0] data_mask(input logic [1:0] sel);
        logic [7:0] m;
        m = 8'hFF;
        unique case (sel)
            DBITS_5: m = 8'h1F;
            DBITS_6: m = 8'h3F;
            DBITS_7: m = 8'h7F;
            DBITS_8: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Pulses bit_tick on the last cycle of every bit period while enabled.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_tick = enable && (cnt_q == CNT_MAX);

    // Count cycles within a bit; reload at each boundary so there is no drift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!enable || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 5-8 data bits, optional parity, 1 or 2 stop bits.
// Frame settings are latched at launch; the serial line is registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tx_data_i,
    input  logic [1:0]  data_bit_num_i,
    input  logic        stop_bit_num_i,
    input  logic        parity_en_i,
    input  logic        parity_type_i,
    input  logic        start_tx_i,
    output logic        tx_o,
    output logic        tx_busy_o,
    output logic        tx_done_o
);

    tx_state_e  state_q;
    tx_state_e  state_n;

    logic       start_q;
    logic       launch;
    logic       bit_tick;

    logic [7:0] data_q;
    logic [1:0] nbits_q;
    logic       stop2_q;
    logic       par_en_q;
    logic       par_odd_q;
    logic       parity_bit;

    logic [2:0] idx_q;
    logic [2:0] idx_n;
    logic       stop_cnt_q;
    logic       stop_cnt_n;
    logic       tx_q;
    logic       tx_n;
    logic       done_q;
    logic       done_n;

    logic       unused_data;

    assign unused_data = ^tx_data_i[31:8];

    assign launch     = (state_q == IDLE) && start_tx_i && !start_q;
    assign parity_bit = (^(data_q & data_mask(nbits_q))) ^ par_odd_q;

    assign tx_o      = tx_q;
    assign tx_busy_o = (state_q != IDLE);
    assign tx_done_o = done_q;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .enable   (tx_busy_o),
        .bit_tick (bit_tick)
    );

    // Edge-detect copy of the start request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start_tx_i;
        end
    end

    // Capture frame settings at launch so later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            nbits_q   <= '0;
            stop2_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
        end else if (launch) begin
            data_q    <= tx_data_i[7:0];
            nbits_q   <= data_bit_num_i;
            stop2_q   <= stop_bit_num_i;
            par_en_q  <= parity_en_i;
            par_odd_q <= parity_type_i;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            stop_cnt_q <= stop_cnt_n;
            tx_q       <= tx_n;
            done_q     <= done_n;
        end
    end

    // Next state plus the line level to present in that state.
    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        stop_cnt_n = stop_cnt_q;
        tx_n       = tx_q;
        done_n     = done_q;
        unique case (state_q)
            IDLE: begin
                tx_n = 1'b1;
                if (launch) begin
                    state_n = START;
                    tx_n    = 1'b0;
                    done_n  = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_n = DATA;
                    idx_n   = '0;
                    tx_n    = data_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_q == last_bit_idx(nbits_q)) begin
                        if (par_en_q) begin
                            state_n = PARITY;
                            tx_n    = parity_bit;
                        end else begin
                            state_n    = STOP;
                            stop_cnt_n = 1'b0;
                            tx_n       = 1'b1;
                        end
                    end else begin
                        idx_n = idx_q + 3'd1;
                        tx_n  = data_q[idx_n];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                    tx_n       = 1'b1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_tick) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with a per-cycle line scoreboard.
// Expected line levels are queued at launch and popped every cycle.
module tb_uart_tx;

    localparam int CLKS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] tx_data_i = '0;
    logic [1:0]  data_bit_num_i = '0;
    logic        stop_bit_num_i = 1'b0;
    logic        parity_en_i = 1'b0;
    logic        parity_type_i = 1'b0;
    logic        start_tx_i = 1'b0;
    logic        tx_o;
    logic        tx_busy_o;
    logic        tx_done_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT (CLKS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_data_i      (tx_data_i),
        .data_bit_num_i (data_bit_num_i),
        .stop_bit_num_i (stop_bit_num_i),
        .parity_en_i    (parity_en_i),
        .parity_type_i  (parity_type_i),
        .start_tx_i     (start_tx_i),
        .tx_o           (tx_o),
        .tx_busy_o      (tx_busy_o),
        .tx_done_o      (tx_done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bit(input logic b);
        for (int c = 0; c < CLKS; c++) exp_q.push_back(b);
    endtask

    // Reference frame: start, LSB-first data, parity, stop bits.
    task automatic push_frame(input logic [7:0] d, input logic [1:0] nb,
                              input logic sb, input logic pe,
                              input logic pt);
        int   n;
        logic p;
        n = 5 + int'(nb);
        p = pt;
        push_bit(1'b0);
        for (int i = 0; i < n; i++) begin
            push_bit(d[i]);
            p = p ^ d[i];
        end
        if (pe) push_bit(p);
        push_bit(1'b1);
        if (sb) push_bit(1'b1);
    endtask

    task automatic drive_cfg(input logic [31:0] d, input logic [1:0] nb,
                             input logic sb, input logic pe,
                             input logic pt);
        tx_data_i      = d;
        data_bit_num_i = nb;
        stop_bit_num_i = sb;
        parity_en_i    = pe;
        parity_type_i  = pt;
    endtask

    task automatic launch(input logic [31:0] d, input logic [1:0] nb,
                          input logic sb, input logic pe, input logic pt);
        @(negedge clk);
        start_tx_i = 1'b0;
        @(negedge clk);
        drive_cfg(d, nb, sb, pe, pt);
        start_tx_i = 1'b1;
        push_frame(d[7:0], nb, sb, pe, pt);
    endtask

    // mode 0: plain, 1: disturb inputs mid-frame, 2: stop at cycle 10.
    task automatic run_frame(input int mode, input string tag);
        int   len;
        logic b;
        len = exp_q.size();
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (mode == 2 && i == 10) return;
            b = exp_q.pop_front();
            chk({tag, " tx"}, {31'b0, tx_o}, {31'b0, b});
            chk({tag, " busy"}, {31'b0, tx_busy_o}, 32'd1);
            if (i == 0) chk({tag, " done clr"}, {31'b0, tx_done_o}, 32'd0);
            if (mode == 1) begin
                if (i == 6) start_tx_i = 1'b0;
                if (i == 8) drive_cfg(32'h0, 2'b00, 1'b1, 1'b1, 1'b1);
                if (i == 12) start_tx_i = 1'b1;
            end
        end
        @(negedge clk);
        chk({tag, " end tx"}, {31'b0, tx_o}, 32'd1);
        chk({tag, " end busy"}, {31'b0, tx_busy_o}, 32'd0);
        chk({tag, " end done"}, {31'b0, tx_done_o}, 32'd1);
    endtask

    task automatic idle_check(input int n, input logic d, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, " tx"}, {31'b0, tx_o}, 32'd1);
            chk({tag, " busy"}, {31'b0, tx_busy_o}, 32'd0);
            chk({tag, " done"}, {31'b0, tx_done_o}, {31'b0, d});
        end
    endtask

    initial begin
        // Reset with start already high: frame launches on first clock.
        drive_cfg(32'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        start_tx_i = 1'b1;
        #12;
        chk("rst tx", {31'b0, tx_o}, 32'd1);
        chk("rst busy", {31'b0, tx_busy_o}, 32'd0);
        chk("rst done", {31'b0, tx_done_o}, 32'd0);
        push_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(0, "8N1");
        idle_check(3, 1'b1, "8N1 hold");

        launch(32'hA3, 2'b10, 1'b1, 1'b1, 1'b0);
        run_frame(0, "7E2");

        launch(32'hFF, 2'b00, 1'b0, 1'b1, 1'b1);
        run_frame(0, "5O1");

        launch(32'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        run_frame(1, "toggle");
        idle_check(12, 1'b1, "no relaunch");

        launch(32'h3C, 2'b11, 1'b1, 1'b1, 1'b1);
        run_frame(2, "abort");
        #2 reset = 1'b1;
        #1;
        chk("abort tx", {31'b0, tx_o}, 32'd1);
        chk("abort busy", {31'b0, tx_busy_o}, 32'd0);
        chk("abort done", {31'b0, tx_done_o}, 32'd0);
        exp_q.delete();
        start_tx_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle_check(2, 1'b0, "post rst");

        launch(32'h96, 2'b01, 1'b0, 1'b1, 1'b0);
        run_frame(0, "after rst");

        idle_check(5, 1'b1, "held high");
        launch(32'hFFFF_FF5A, 2'b11, 1'b1, 1'b0, 1'b0);
        run_frame(0, "reedge");

        for (int k = 0; k < 4; k++) begin
            launch($urandom, 2'($urandom_range(3, 0)),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   1'($urandom_range(1, 0)));
            run_frame(0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
